mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wcnt;
  logic       win_d;
  logic       lat_we;
  logic       any_req;
  logic       grant_d;
  logic       force_i;

  assign any_req = i_req | d_req;
  assign grant_d = d_req & ~force_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  assign force_i = i_req && (starve_cnt == CNT_MAX);

  // Counts data grants taken while a fetch was waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!grant_d || !i_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = CMD;
      CMD:  state_nxt = WAIT;
      WAIT: if (wcnt == LAT_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_ack = 1'b0;
    d_ack = 1'b0;
    unique case (1'b1)
      (state == DONE): begin
        i_ack = ~win_d;
        d_ack = win_d;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt      <= '0;
      win_d     <= 1'b0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: if (any_req) begin
          win_d    <= grant_d;
          lat_we   <= grant_d & d_we;
          mem_en   <= 1'b1;
          mem_we   <= grant_d & d_we;
          mem_addr <= grant_d ? d_addr : i_addr;
          if (grant_d) mem_wdata <= d_wdata;
        end
        CMD: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 4'd1;
          // Read data is valid only in the last wait cycle.
          if (wcnt == LAT_LAST) begin
            if (!win_d) begin
              i_rdata <= mem_rdata;
            end else if (lat_we) begin
              d_rdata <= '0;
            end else begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
